clreq_sched: RTL and testbench
==============================

Name: clreq_sched

Overview:
- Issue scheduler between the 16-way cacheline request merger and the memory port of the multi-stream buffer.
- Accepts merged cacheline requests (stream id), allocates a memory tag from a fixed pool and enforces a per-stream outstanding limit.
- Issues tagged requests to memory and maps returning tagged responses back to the stream id.
- Provides a flush sequence that blocks new issue until all outstanding requests have returned.

Parameters:
CLID_W, 4, stream id width (16 streams)
NTAGS, 8, tag pool size (power of 2)
TAG_W, 3, log2(NTAGS)
MAX_OUT, 2, max outstanding requests per stream (1..3)
CNT_W, 2, per-stream counter width, holds MAX_OUT

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
i_req_v  in  1  merged request valid
i_req_r  out  1  merged request ready
i_req_clid  in  CLID_W  requesting stream id
o_mreq_v  out  1  memory request valid
o_mreq_r  in  1  memory request ready
o_mreq_clid  out  CLID_W  stream id of issued request
o_mreq_tag  out  TAG_W  allocated tag
i_mrsp_v  in  1  memory response valid
i_mrsp_r  out  1  memory response ready
i_mrsp_tag  in  TAG_W  tag of returning response
o_rsp_v  out  1  response to stream logic valid
o_rsp_r  in  1  response ready
o_rsp_clid  out  CLID_W  stream id owning response
i_flush  in  1  flush request pulse
o_flush_done  out  1  one-cycle flush completion pulse
o_outstanding  out  TAG_W+1  number of busy tags
o_err  out  1  sticky protocol error

Behaviour:
- Reset (reset=0, async): busy vector=0, all per-stream counters=0, o_mreq_v=0, o_rsp_v=0, o_flush_done=0, o_err=0, o_outstanding=0, state=RUN. Tag table contents don't care.
- Handshake: a transfer occurs on a cycle with v&r high. Valid, once high, holds with stable data until accepted.
- Issue readiness: i_req_r = (state==RUN) & (any tag free) & (cnt[i_req_clid] < MAX_OUT) & (~o_mreq_v | o_mreq_r). i_req_r depends combinationally on i_req_clid.
- Tag allocation:
  - On request accept, allocate the lowest-index free tag from busy as of the start of the cycle, then set its busy bit.
  - Write table[tag] <= clid and increment cnt[clid].
  - Load the output register: o_mreq_v=1 with clid and tag. Latency is 1 cycle accept-to-valid.
- Output register behaviour: o_mreq_v clears on o_mreq_r with no new accept. Back-to-back accepts sustain 1 request/cycle.
- Response readiness: i_mrsp_r = ~o_rsp_v | o_rsp_r.
- Response accept, tag busy:
  - o_rsp_v=1 and o_rsp_clid=table[tag] next cycle.
  - Clear busy[tag] and decrement cnt[table[tag]].
- Response accept, tag not busy: response consumed and not forwarded; o_err set sticky until reset.
- Simultaneous accept and response in one cycle:
  - A tag freed this cycle is not allocatable until the next cycle.
  - Same-stream increment and decrement leave the counter unchanged.
  - o_outstanding = popcount(busy), registered, updated with busy.
- Full pool: all NTAGS busy gives i_req_r=0.
- Per-stream cap: a stream at MAX_OUT is blocked; other streams proceed.
- Flush state machine:
  - RUN: i_flush=1 -> FLUSH.
  - FLUSH: i_req_r=0; responses continue. When busy==0 & ~o_mreq_v & ~o_rsp_v -> DONE.
  - DONE: o_flush_done=1 for exactly this cycle -> RUN.
  - i_flush is ignored outside RUN. If held high, the sequence repeats.
  - Idle flush: i_flush in cycle 0 gives o_flush_done in cycle 2.
- Reset mid-operation: all tags freed immediately. Later responses carrying stale tags set o_err.

Test Plan:
- Reset then single request clid=5 -> o_mreq_v next cycle, tag=0, clid=5; o_outstanding=1. Response tag=0 -> o_rsp_clid=5 next cycle; o_outstanding=0.
- Stream 3 issues 3 back-to-back requests, o_mreq_r=1 -> tags 0,1 issued; third blocked (i_req_r=0) until a response for tag 0 or 1 is accepted, then issued with tag 0 or the freed tag.
- 8 requests from streams 0..7 without responses -> tags 0..7, o_outstanding=8, i_req_r=0. Response tag 4 and request clid=8 in same cycle -> request blocked that cycle, gets tag 4 the next.
- o_mreq_r=0 for 5 cycles with a pending request -> o_mreq_v, clid and tag stable; i_req_r=0. o_rsp_r=0 -> i_mrsp_r=0, no response lost.
- Flush with 2 outstanding -> i_req_r=0 immediately after. o_flush_done pulses exactly 1 cycle after the last response drains from o_rsp. Flush when idle -> o_flush_done in cycle 2.
- Response for non-busy tag 6 -> o_rsp_v stays 0, o_err=1 until reset. Assert reset mid-traffic -> all outputs to reset values in the same cycle (async).

Source files
------------

// File: rtl/clreq_sched.sv
// Issue scheduler: allocates memory tags to merged cacheline requests, caps
// per-stream outstanding requests, maps responses back to streams, and flushes.
module clreq_sched #(
  parameter int CLID_W  = 4,
  parameter int NTAGS   = 8,
  parameter int TAG_W   = 3,
  parameter int MAX_OUT = 2,
  parameter int CNT_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req_v,
  output logic              i_req_r,
  input  logic [CLID_W-1:0] i_req_clid,
  output logic              o_mreq_v,
  input  logic              o_mreq_r,
  output logic [CLID_W-1:0] o_mreq_clid,
  output logic [TAG_W-1:0]  o_mreq_tag,
  input  logic              i_mrsp_v,
  output logic              i_mrsp_r,
  input  logic [TAG_W-1:0]  i_mrsp_tag,
  output logic              o_rsp_v,
  input  logic              o_rsp_r,
  output logic [CLID_W-1:0] o_rsp_clid,
  input  logic              i_flush,
  output logic              o_flush_done,
  output logic [TAG_W:0]    o_outstanding,
  output logic              o_err
);

  localparam int NSTR = 1 << CLID_W;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

  typedef enum logic [1:0] {RUN, FLUSH, DONE} state_e;

  state_e                          state_q;
  logic                            flush_done_q;
  logic [NTAGS-1:0]                busy_q, busy_d;
  logic [NSTR-1:0][CNT_W-1:0]      cnt_q, cnt_d;
  logic [NTAGS-1:0][CLID_W-1:0]    table_q, table_d;
  logic                            mreq_v_q, mreq_v_d;
  logic [CLID_W-1:0]               mreq_clid_q, mreq_clid_d;
  logic [TAG_W-1:0]                mreq_tag_q, mreq_tag_d;
  logic                            rsp_v_q, rsp_v_d;
  logic [CLID_W-1:0]               rsp_clid_q, rsp_clid_d;
  logic                            err_q, err_d;
  logic [TAG_W:0]                  outstanding_q, outstanding_d;

  logic              req_r, req_acc, rsp_r, rsp_acc, drained;
  logic [TAG_W-1:0]  alloc_tag;
  logic [CLID_W-1:0] rsp_owner;

  assign req_r = (state_q == RUN) & ~(&busy_q) & (cnt_q[i_req_clid] < MAX_CNT)
               & (~mreq_v_q | o_mreq_r);
  assign req_acc   = i_req_v & req_r;
  assign rsp_r     = ~rsp_v_q | o_rsp_r;
  assign rsp_acc   = i_mrsp_v & rsp_r;
  assign rsp_owner = table_q[i_mrsp_tag];
  assign drained   = (busy_q == '0) & ~mreq_v_q & ~rsp_v_q;

  // Allocation sees only start-of-cycle busy bits, so a tag freed this cycle waits a cycle.
  always_comb begin
    alloc_tag = '0;
    for (int i = NTAGS - 1; i >= 0; i--) begin
      if (!busy_q[i]) alloc_tag = TAG_W'(i);
    end
  end

  always_comb begin
    busy_d      = busy_q;
    cnt_d       = cnt_q;
    table_d     = table_q;
    mreq_v_d    = mreq_v_q & ~o_mreq_r;
    mreq_clid_d = mreq_clid_q;
    mreq_tag_d  = mreq_tag_q;
    rsp_v_d     = rsp_v_q & ~o_rsp_r;
    rsp_clid_d  = rsp_clid_q;
    err_d       = err_q;

    if (req_acc) begin
      busy_d[alloc_tag]  = 1'b1;
      table_d[alloc_tag] = i_req_clid;
      cnt_d[i_req_clid]  = cnt_d[i_req_clid] + CNT_W'(1);
      mreq_v_d           = 1'b1;
      mreq_clid_d        = i_req_clid;
      mreq_tag_d         = alloc_tag;
    end

    // Decrement applies after the increment so a same-stream pair nets to zero.
    if (rsp_acc) begin
      if (busy_q[i_mrsp_tag]) begin
        busy_d[i_mrsp_tag] = 1'b0;
        cnt_d[rsp_owner]   = cnt_d[rsp_owner] - CNT_W'(1);
        rsp_v_d            = 1'b1;
        rsp_clid_d         = rsp_owner;
      end else begin
        err_d = 1'b1;
      end
    end

    outstanding_d = '0;
    for (int i = 0; i < NTAGS; i++) begin
      outstanding_d = outstanding_d + (TAG_W + 1)'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q        <= '0;
      cnt_q         <= '0;
      mreq_v_q      <= 1'b0;
      mreq_clid_q   <= '0;
      mreq_tag_q    <= '0;
      rsp_v_q       <= 1'b0;
      rsp_clid_q    <= '0;
      err_q         <= 1'b0;
      outstanding_q <= '0;
    end else begin
      busy_q        <= busy_d;
      cnt_q         <= cnt_d;
      mreq_v_q      <= mreq_v_d;
      mreq_clid_q   <= mreq_clid_d;
      mreq_tag_q    <= mreq_tag_d;
      rsp_v_q       <= rsp_v_d;
      rsp_clid_q    <= rsp_clid_d;
      err_q         <= err_d;
      outstanding_q <= outstanding_d;
    end
  end

  always_ff @(posedge clk) begin
    table_q <= table_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= RUN;
      flush_done_q <= 1'b0;
    end else begin
      flush_done_q <= 1'b0;
      case (state_q)
        RUN:   if (i_flush) state_q <= FLUSH;
        FLUSH: if (drained) begin
                 state_q      <= DONE;
                 flush_done_q <= 1'b1;
               end
        DONE:  state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  assign i_req_r       = req_r;
  assign i_mrsp_r      = rsp_r;
  assign o_mreq_v      = mreq_v_q;
  assign o_mreq_clid   = mreq_clid_q;
  assign o_mreq_tag    = mreq_tag_q;
  assign o_rsp_v       = rsp_v_q;
  assign o_rsp_clid    = rsp_clid_q;
  assign o_flush_done  = flush_done_q;
  assign o_outstanding = outstanding_q;
  assign o_err         = err_q;

endmodule

// File: tb/tb_clreq_sched.sv
// Directed bench for clreq_sched: tag allocation, stream caps, backpressure,
// flush sequencing, error reporting and asynchronous reset.
module tb_clreq_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_v;
  logic       req_r;
  logic [3:0] req_clid;
  logic       mreq_v;
  logic       mreq_r;
  logic [3:0] mreq_clid;
  logic [2:0] mreq_tag;
  logic       mrsp_v;
  logic       mrsp_r;
  logic [2:0] mrsp_tag;
  logic       rsp_v;
  logic       rsp_r;
  logic [3:0] rsp_clid;
  logic       flush;
  logic       flush_done;
  logic [3:0] outstanding;
  logic       err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  clreq_sched dut (
    .clk          (clk),
    .reset        (reset),
    .i_req_v      (req_v),
    .i_req_r      (req_r),
    .i_req_clid   (req_clid),
    .o_mreq_v     (mreq_v),
    .o_mreq_r     (mreq_r),
    .o_mreq_clid  (mreq_clid),
    .o_mreq_tag   (mreq_tag),
    .i_mrsp_v     (mrsp_v),
    .i_mrsp_r     (mrsp_r),
    .i_mrsp_tag   (mrsp_tag),
    .o_rsp_v      (rsp_v),
    .o_rsp_r      (rsp_r),
    .o_rsp_clid   (rsp_clid),
    .i_flush      (flush),
    .o_flush_done (flush_done),
    .o_outstanding(outstanding),
    .o_err        (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req_v = 1'b0; req_clid = '0; mreq_r = 1'b1;
    mrsp_v = 1'b0; mrsp_tag = '0; rsp_r = 1'b1; flush = 1'b0;
    tick();
    vectors++;
    if (mreq_v !== 1'b0 || rsp_v !== 1'b0 || flush_done !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: mreq_v=%b rsp_v=%b done=%b err=%b, want all 0",
               mreq_v, rsp_v, flush_done, err);
    end
    vectors++;
    if (outstanding !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outstanding: got %0d want 0", outstanding);
    end
    vectors++;
    if (req_r !== 1'b1 || mrsp_r !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_ready: req_r=%b mrsp_r=%b want 1 1", req_r, mrsp_r);
    end
    reset = 1'b1;
  endtask

  task automatic test_single();
    req_v = 1'b1; req_clid = 4'd5;
    vectors++;
    if (req_r !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL single_ready: got %b want 1", req_r);
    end
    tick();
    req_v = 1'b0;
    vectors++;
    if (mreq_v !== 1'b1 || mreq_clid !== 4'd5 || mreq_tag !== 3'd0 || outstanding !== 4'd1) begin
      miscompares++;
      $display("[TB] FAIL single_issue: v=%b clid=%0d tag=%0d out=%0d want 1 5 0 1",
               mreq_v, mreq_clid, mreq_tag, outstanding);
    end
    mrsp_v = 1'b1; mrsp_tag = 3'd0;
    tick();
    mrsp_v = 1'b0;
    vectors++;
    if (rsp_v !== 1'b1 || rsp_clid !== 4'd5 || outstanding !== 4'd0 || mreq_v !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_rsp: rsp_v=%b clid=%0d out=%0d mreq_v=%b want 1 5 0 0",
               rsp_v, rsp_clid, outstanding, mreq_v);
    end
    tick();
    vectors++;
    if (rsp_v !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_rsp_drop: rsp_v=%b want 0", rsp_v);
    end
  endtask

  task automatic test_stream_cap();
    req_v = 1'b1; req_clid = 4'd3;
    tick();
    vectors++;
    if (mreq_tag !== 3'd0 || req_r !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL cap_first: tag=%0d req_r=%b want 0 1", mreq_tag, req_r);
    end
    tick();
    vectors++;
    if (mreq_tag !== 3'd1 || mreq_clid !== 4'd3 || outstanding !== 4'd2 || req_r !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL cap_second: tag=%0d clid=%0d out=%0d req_r=%b want 1 3 2 0",
               mreq_tag, mreq_clid, outstanding, req_r);
    end
    tick();
    vectors++;
    if (req_r !== 1'b0 || mreq_v !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL cap_blocked: req_r=%b mreq_v=%b want 0 0", req_r, mreq_v);
    end
    req_v = 1'b0; req_clid = 4'd9;
    #1;
    vectors++;
    if (req_r !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL cap_other_stream: req_r=%b want 1", req_r);
    end
    req_v = 1'b1; req_clid = 4'd3;
    mrsp_v = 1'b1; mrsp_tag = 3'd1;
    #1;
    vectors++;
    if (req_r !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL cap_same_cycle: req_r=%b want 0", req_r);
    end
    tick();
    mrsp_v = 1'b0;
    vectors++;
    if (req_r !== 1'b1 || rsp_v !== 1'b1 || rsp_clid !== 4'd3) begin
      miscompares++;
      $display("[TB] FAIL cap_release: req_r=%b rsp_v=%b clid=%0d want 1 1 3", req_r, rsp_v, rsp_clid);
    end
    tick();
    req_v = 1'b0;
    vectors++;
    if (mreq_v !== 1'b1 || mreq_tag !== 3'd1 || mreq_clid !== 4'd3) begin
      miscompares++;
      $display("[TB] FAIL cap_third: v=%b tag=%0d clid=%0d want 1 1 3", mreq_v, mreq_tag, mreq_clid);
    end
    for (int t = 0; t < 2; t++) begin
      mrsp_v = 1'b1; mrsp_tag = 3'(t);
      tick();
      vectors++;
      if (rsp_v !== 1'b1 || rsp_clid !== 4'd3) begin
        miscompares++;
        $display("[TB] FAIL cap_drain%0d: rsp_v=%b clid=%0d want 1 3", t, rsp_v, rsp_clid);
      end
    end
    mrsp_v = 1'b0;
    tick();
    vectors++;
    if (outstanding !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL cap_empty: out=%0d want 0", outstanding);
    end
  endtask

  task automatic test_full_pool();
    logic [3:0] owner;
    for (int i = 0; i < 8; i++) begin
      req_v = 1'b1; req_clid = 4'(i);
      tick();
      vectors++;
      if (mreq_tag !== 3'(i) || mreq_clid !== 4'(i)) begin
        miscompares++;
        $display("[TB] FAIL pool_alloc%0d: tag=%0d clid=%0d want %0d %0d", i, mreq_tag, mreq_clid, i, i);
      end
    end
    req_clid = 4'd8;
    mrsp_v = 1'b1; mrsp_tag = 3'd4;
    #1;
    vectors++;
    if (outstanding !== 4'd8 || req_r !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL pool_full: out=%0d req_r=%b want 8 0", outstanding, req_r);
    end
    tick();
    mrsp_v = 1'b0;
    vectors++;
    if (rsp_v !== 1'b1 || rsp_clid !== 4'd4 || mreq_v !== 1'b0 || req_r !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL pool_free: rsp_v=%b clid=%0d mreq_v=%b req_r=%b want 1 4 0 1",
               rsp_v, rsp_clid, mreq_v, req_r);
    end
    tick();
    req_v = 1'b0;
    vectors++;
    if (mreq_v !== 1'b1 || mreq_tag !== 3'd4 || mreq_clid !== 4'd8 || outstanding !== 4'd8) begin
      miscompares++;
      $display("[TB] FAIL pool_reuse: v=%b tag=%0d clid=%0d out=%0d want 1 4 8 8",
               mreq_v, mreq_tag, mreq_clid, outstanding);
    end
    for (int t = 0; t < 8; t++) begin
      owner = (t == 4) ? 4'd8 : 4'(t);
      mrsp_v = 1'b1; mrsp_tag = 3'(t);
      tick();
      vectors++;
      if (rsp_v !== 1'b1 || rsp_clid !== owner) begin
        miscompares++;
        $display("[TB] FAIL pool_drain%0d: rsp_v=%b clid=%0d want 1 %0d", t, rsp_v, rsp_clid, owner);
      end
    end
    mrsp_v = 1'b0;
    tick();
    vectors++;
    if (outstanding !== 4'd0 || err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL pool_empty: out=%0d err=%b want 0 0", outstanding, err);
    end
  endtask

  task automatic test_back_to_back_stall();
    mreq_r = 1'b0; req_v = 1'b1; req_clid = 4'd2;
    tick();
    req_clid = 4'd6;
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (req_r !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL stall_ready%0d: req_r=%b want 0", k, req_r);
      end
      tick();
      vectors++;
      if (mreq_v !== 1'b1 || mreq_clid !== 4'd2 || mreq_tag !== 3'd0) begin
        miscompares++;
        $display("[TB] FAIL stall_hold%0d: v=%b clid=%0d tag=%0d want 1 2 0", k, mreq_v, mreq_clid, mreq_tag);
      end
    end
    mreq_r = 1'b1;
    tick();
    req_v = 1'b0;
    vectors++;
    if (mreq_v !== 1'b1 || mreq_clid !== 4'd6 || mreq_tag !== 3'd1) begin
      miscompares++;
      $display("[TB] FAIL stall_next: v=%b clid=%0d tag=%0d want 1 6 1", mreq_v, mreq_clid, mreq_tag);
    end
    tick();
    rsp_r = 1'b0; mrsp_v = 1'b1; mrsp_tag = 3'd0;
    tick();
    mrsp_tag = 3'd1;
    #1;
    vectors++;
    if (mrsp_r !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rsp_stall_ready: mrsp_r=%b want 0", mrsp_r);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if (rsp_v !== 1'b1 || rsp_clid !== 4'd2 || outstanding !== 4'd1) begin
        miscompares++;
        $display("[TB] FAIL rsp_stall_hold%0d: v=%b clid=%0d out=%0d want 1 2 1", k, rsp_v, rsp_clid, outstanding);
      end
    end
    rsp_r = 1'b1;
    tick();
    mrsp_v = 1'b0;
    vectors++;
    if (rsp_v !== 1'b1 || rsp_clid !== 4'd6 || outstanding !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL rsp_stall_release: v=%b clid=%0d out=%0d want 1 6 0", rsp_v, rsp_clid, outstanding);
    end
    tick();
  endtask

  task automatic test_flush();
    req_v = 1'b1; req_clid = 4'd10;
    tick();
    req_clid = 4'd11;
    tick();
    req_v = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; req_clid = 4'd12;
    #1;
    vectors++;
    if (req_r !== 1'b0 || outstanding !== 4'd2) begin
      miscompares++;
      $display("[TB] FAIL flush_block: req_r=%b out=%0d want 0 2", req_r, outstanding);
    end
    mrsp_v = 1'b1; mrsp_tag = 3'd0;
    tick();
    mrsp_tag = 3'd1;
    vectors++;
    if (rsp_clid !== 4'd10 || flush_done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flush_rsp0: clid=%0d done=%b want 10 0", rsp_clid, flush_done);
    end
    tick();
    mrsp_v = 1'b0;
    vectors++;
    if (rsp_clid !== 4'd11 || flush_done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flush_rsp1: clid=%0d done=%b want 11 0", rsp_clid, flush_done);
    end
    tick();
    vectors++;
    if (rsp_v !== 1'b0 || flush_done !== 1'b0 || req_r !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flush_drained: rsp_v=%b done=%b req_r=%b want 0 0 0", rsp_v, flush_done, req_r);
    end
    tick();
    vectors++;
    if (flush_done !== 1'b1 || req_r !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flush_done_pulse: done=%b req_r=%b want 1 0", flush_done, req_r);
    end
    tick();
    vectors++;
    if (flush_done !== 1'b0 || req_r !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL flush_resume: done=%b req_r=%b want 0 1", flush_done, req_r);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    vectors++;
    if (flush_done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL idle_flush_c1: done=%b want 0", flush_done);
    end
    tick();
    vectors++;
    if (flush_done !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL idle_flush_c2: done=%b want 1", flush_done);
    end
    tick();
    vectors++;
    if (flush_done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL idle_flush_c3: done=%b want 0", flush_done);
    end
  endtask

  task automatic test_error();
    mrsp_v = 1'b1; mrsp_tag = 3'd6;
    tick();
    mrsp_v = 1'b0;
    vectors++;
    if (rsp_v !== 1'b0 || err !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL err_set: rsp_v=%b err=%b want 0 1", rsp_v, err);
    end
    tick();
    tick();
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL err_sticky: err=%b want 1", err);
    end
  endtask

  task automatic test_reset_mid();
    req_v = 1'b1; req_clid = 4'd1;
    tick();
    req_clid = 4'd2;
    tick();
    req_v = 1'b0;
    vectors++;
    if (mreq_v !== 1'b1 || outstanding !== 4'd2) begin
      miscompares++;
      $display("[TB] FAIL mid_pre: mreq_v=%b out=%0d want 1 2", mreq_v, outstanding);
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (mreq_v !== 1'b0 || rsp_v !== 1'b0 || outstanding !== 4'd0 || err !== 1'b0 || flush_done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mid_async: mreq_v=%b rsp_v=%b out=%0d err=%b done=%b want 0 0 0 0 0",
               mreq_v, rsp_v, outstanding, err, flush_done);
    end
    #1 reset = 1'b1;
    tick();
    mrsp_v = 1'b1; mrsp_tag = 3'd0;
    tick();
    mrsp_v = 1'b0;
    vectors++;
    if (rsp_v !== 1'b0 || err !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mid_stale: rsp_v=%b err=%b want 0 1", rsp_v, err);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream_cap();
    test_full_pool();
    test_back_to_back_stall();
    test_flush();
    test_error();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
